fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, fetches 32-bit words from instruction memory over a
//  req/gnt + rvalid handshake, presents instr_o/opcode_o/pc_o to the decode side.
//  opcode_o drives control.opcode_i. Branch redirect from execute; stall from downstream.
//  One outstanding request at a time.
// PARAMETERS
//  XLEN      32            address / PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset (bits [1:0] must be 0)
// PORTS
//  clk_i            in   1     single clock, rising edge
//  rst_n_i          in   1     asynchronous, active-low reset
//  imem_req_o       out  1     fetch request; held until imem_gnt_i
//  imem_addr_o      out  XLEN  word-aligned fetch address; stable while req=1 and gnt=0
//  imem_gnt_i       in   1     request accepted this cycle
//  imem_rvalid_i    in   1     read data valid; earliest one cycle after gnt
//  imem_rdata_i     in   32    instruction word
//  branch_taken_i   in   1     redirect request, 1-cycle pulse
//  branch_target_i  in   XLEN  redirect address; bits [1:0] ignored (forced to 00)
//  stall_i          in   1     downstream not ready; instruction held while 1
//  instr_valid_o    out  1     instr_o/opcode_o/pc_o valid
//  instr_o          out  32    fetched instruction
//  opcode_o         out  7     instr_o[6:0]
//  pc_o             out  XLEN  address of instr_o
// BEHAVIOUR
//  Reset (async, rst_n_i=0):
//  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, pc_o=RESET_PC.
//  - Outputs: instr_o=32'h0000_0013 (NOP), opcode_o=7'b0010011.
//  - Internal: fetch_pc=RESET_PC, discard=0, state=IDLE.
//  Registers: fetch_pc (next address), discard flag, FSM IDLE/REQ/WAIT/HOLD. All outputs registered.
//  - IDLE: req=0; next cycle -> REQ. Entered from reset and after a redirect in REQ.
//  - REQ: req=1, addr=fetch_pc.
//    - gnt -> WAIT.
//    - branch without gnt: fetch_pc<=target, -> IDLE (req drops 1 cycle, then new address).
//    - branch with gnt: fetch_pc<=target, discard<=1, -> WAIT.
//  - WAIT: req=0.
//    - branch: fetch_pc<=target, discard<=1.
//    - rvalid & discard (incl. same-cycle branch): drop data, discard<=0, -> REQ.
//    - rvalid & !discard: instr_o<=rdata, opcode_o<=rdata[6:0], pc_o<=fetch_pc,
//      fetch_pc<=fetch_pc+4, instr_valid_o<=1, -> HOLD.
//  - HOLD: instr_valid_o=1, outputs frozen.
//    - branch (priority over stall): fetch_pc<=target, instr_valid_o<=0, -> REQ.
//    - else !stall_i: instruction consumed, instr_valid_o<=0, -> REQ.
//    - else stay.
//  Latency: gnt in cycle n, rvalid n+1 -> instr_valid_o high in n+2. Max rate 1 instr / 3 cycles.
//  PC arithmetic modulo 2^XLEN: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  rvalid outside WAIT: ignored (simulation assertion error). gnt outside REQ: ignored.
//  Reset mid-transaction: state cleared; late rvalid lands in IDLE/REQ and is ignored.
// STRUCTURE
//  Shared package riscv_pkg:
//  - XLEN; NOP_INSTR = 32'h0000_0013.
//  - OPCODE_R 0110011, OPCODE_LW 0000011, OPCODE_SW 0100011, OPCODE_BEQ 1100011, OPCODE_OPIMM 0010011.
//  - Same constants used by control and its bench.
//  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD).
//  Single module, no sub-module; PC update mux kept in one always block.
// TESTING
//  1 Reset, then 0-wait memory returning 32'h0000_0033 for addr 0 -> req in cycle 1 with addr 0;
//    instr_valid_o=1, opcode_o=7'b0110011, pc_o=0; next fetch addr=4.
//  2 gnt withheld 3 cycles -> imem_req_o held, imem_addr_o stable at 4, no second request issued.
//  3 stall_i=1 for 5 cycles in HOLD -> instr_o/pc_o unchanged, imem_req_o=0; release -> REQ at pc+4.
//  4 branch_taken_i, target 32'h0000_0103, in WAIT -> returning word dropped (instr_valid_o stays 0);
//    next request addr=32'h0000_0100.
//  5 branch and stall both in HOLD (target 32'h40) -> instr_valid_o=0 next cycle, req to 32'h40.
//  6 RESET_PC=32'hFFFF_FFFC -> second fetch addr=32'h0000_0000.
//    rst_n_i pulsed low during WAIT -> all outputs at reset values immediately; stale rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPCODE_R     = 7'b0110011;
    localparam logic [6:0] OPCODE_LW    = 7'b0000011;
    localparam logic [6:0] OPCODE_SW    = 7'b0100011;
    localparam logic [6:0] OPCODE_BEQ   = 7'b1100011;
    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and fetches one word at a time over req/gnt + rvalid.
// Latency: gnt in cycle n, rvalid in n+1 -> instr_valid_o in n+2 (at most 1 instr / 3 cycles).
// Backpressure: stall_i holds the presented instruction; no new request is made until it is consumed.
// Ports: clk_i/rst_n_i; imem_* memory handshake; branch_* redirect from execute;
//        stall_i from decode; instr_valid_o/instr_o/opcode_o/pc_o towards decode.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            stall_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [6:0]      opcode_o,
    output logic [XLEN-1:0] pc_o
);
    import riscv_pkg::fetch_state_t;
    import riscv_pkg::NOP_INSTR;
    import riscv_pkg::IDLE;
    import riscv_pkg::REQ;
    import riscv_pkg::WAIT;
    import riscv_pkg::HOLD;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic            discard;   // the in-flight response belongs to a squashed path
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic            valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] branch_pc;

    assign branch_pc = {branch_target_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_q     <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    req_q  <= 1'b1;
                    addr_q <= fetch_pc;
                    state  <= REQ;
                end
                REQ: begin
                    if (branch_taken_i) begin
                        fetch_pc <= branch_pc;
                        req_q    <= 1'b0;
                        if (imem_gnt_i) begin
                            // Old-path word is already on its way; throw it away.
                            discard <= 1'b1;
                            state   <= WAIT;
                        end else begin
                            // Drop req for a cycle so the address change is never seen under req.
                            state <= IDLE;
                        end
                    end else if (imem_gnt_i) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (discard || branch_taken_i) begin
                            discard <= 1'b0;
                            req_q   <= 1'b1;
                            state   <= REQ;
                            if (branch_taken_i) begin
                                fetch_pc <= branch_pc;
                                addr_q   <= branch_pc;
                            end else begin
                                addr_q <= fetch_pc;
                            end
                        end else begin
                            instr_q  <= imem_rdata_i;
                            pc_q     <= fetch_pc;
                            fetch_pc <= fetch_pc + XLEN'(4);
                            valid_q  <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (branch_taken_i) begin
                        fetch_pc <= branch_pc;
                        discard  <= 1'b1;
                    end
                end
                HOLD: begin
                    // A redirect squashes the held instruction even while decode is stalled.
                    if (branch_taken_i) begin
                        fetch_pc <= branch_pc;
                        valid_q  <= 1'b0;
                        req_q    <= 1'b1;
                        addr_q   <= branch_pc;
                        state    <= REQ;
                    end else if (!stall_i) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc;
                        state   <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[6:0];
    assign pc_o          = pc_q;

    // Memory must only return data for the single outstanding request.
    rvalid_only_in_wait: assert property (
        @(posedge clk_i) disable iff (!rst_n_i) imem_rvalid_i |-> (state == WAIT)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        gnt, rvalid, br, stall;
    logic [31:0] rdata, tgt;
    logic        req, vld;
    logic [31:0] addr, instr, pc;
    logic [6:0]  opc;

    logic        b_rst_n, b_gnt, b_rvalid, b_br, b_stall;
    logic [31:0] b_rdata, b_tgt;
    logic        b_req, b_vld;
    logic [31:0] b_addr, b_instr, b_pc;
    logic [6:0]  b_opc;

    int pass_cnt;
    int total_cnt;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .branch_taken_i(br), .branch_target_i(tgt), .stall_i(stall),
        .instr_valid_o(vld), .instr_o(instr), .opcode_o(opc), .pc_o(pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_n_i(b_rst_n),
        .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
        .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
        .branch_taken_i(b_br), .branch_target_i(b_tgt), .stall_i(b_stall),
        .instr_valid_o(b_vld), .instr_o(b_instr), .opcode_o(b_opc), .pc_o(b_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        total_cnt++; if (req !== 1'b0) $display("FAIL rst_req: got %b want 0", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", addr); else pass_cnt++;
        total_cnt++; if (vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", vld); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", pc); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0000_0013) $display("FAIL rst_instr: got %h want 00000013", instr); else pass_cnt++;
        total_cnt++; if (opc !== 7'b0010011) $display("FAIL rst_opc: got %b want 0010011", opc); else pass_cnt++;
        total_cnt++; if (b_addr !== 32'hFFFF_FFFC) $display("FAIL rst_b_addr: got %h want fffffffc", b_addr); else pass_cnt++;
        rst_n   = 1'b1;
        b_rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL zw_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0) $display("FAIL zw_addr: got %h want 00000000", addr); else pass_cnt++;
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        total_cnt++; if (req !== 1'b0) $display("FAIL zw_req_drop: got %b want 0", req); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'h0000_0033;
        @(negedge clk);
        rvalid = 1'b0;
        total_cnt++; if (vld !== 1'b1) $display("FAIL zw_vld: got %b want 1", vld); else pass_cnt++;
        total_cnt++; if (opc !== 7'b0110011) $display("FAIL zw_opc: got %b want 0110011", opc); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0000_0033) $display("FAIL zw_instr: got %h want 00000033", instr); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL zw_pc: got %h want 00000000", pc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL zw_next_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h4) $display("FAIL zw_next_addr: got %h want 00000004", addr); else pass_cnt++;
        total_cnt++; if (vld !== 1'b0) $display("FAIL zw_next_vld: got %b want 0", vld); else pass_cnt++;
    endtask

    task automatic test_gnt_withheld();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (req !== 1'b1) $display("FAIL gw_req[%0d]: got %b want 1", i, req); else pass_cnt++;
            total_cnt++; if (addr !== 32'h4) $display("FAIL gw_addr[%0d]: got %h want 00000004", i, addr); else pass_cnt++;
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        total_cnt++; if (req !== 1'b0) $display("FAIL gw_req_drop: got %b want 0", req); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'h0040_2083; stall = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (vld !== 1'b1) $display("FAIL st_vld[%0d]: got %b want 1", i, vld); else pass_cnt++;
            total_cnt++; if (instr !== 32'h0040_2083) $display("FAIL st_instr[%0d]: got %h want 00402083", i, instr); else pass_cnt++;
            total_cnt++; if (pc !== 32'h4) $display("FAIL st_pc[%0d]: got %h want 00000004", i, pc); else pass_cnt++;
            total_cnt++; if (req !== 1'b0) $display("FAIL st_req[%0d]: got %b want 0", i, req); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (opc !== 7'b0000011) $display("FAIL st_opc: got %b want 0000011", opc); else pass_cnt++;
        stall = 1'b0;
        @(negedge clk);
        total_cnt++; if (vld !== 1'b0) $display("FAIL st_release_vld: got %b want 0", vld); else pass_cnt++;
        total_cnt++; if (req !== 1'b1) $display("FAIL st_release_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h8) $display("FAIL st_release_addr: got %h want 00000008", addr); else pass_cnt++;
    endtask

    task automatic test_branch_in_wait();
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        br = 1'b1; tgt = 32'h0000_0103;
        @(negedge clk);
        br = 1'b0;
        total_cnt++; if (vld !== 1'b0) $display("FAIL bw_vld_a: got %b want 0", vld); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0;
        total_cnt++; if (vld !== 1'b0) $display("FAIL bw_vld_b: got %b want 0", vld); else pass_cnt++;
        total_cnt++; if (req !== 1'b1) $display("FAIL bw_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0000_0100) $display("FAIL bw_addr: got %h want 00000100", addr); else pass_cnt++;
    endtask

    task automatic test_branch_over_stall();
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h0020_8663;
        @(negedge clk);
        rvalid = 1'b0;
        total_cnt++; if (vld !== 1'b1) $display("FAIL bs_vld: got %b want 1", vld); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0000_0100) $display("FAIL bs_pc: got %h want 00000100", pc); else pass_cnt++;
        total_cnt++; if (opc !== 7'b1100011) $display("FAIL bs_opc: got %b want 1100011", opc); else pass_cnt++;
        stall = 1'b1; br = 1'b1; tgt = 32'h0000_0040;
        @(negedge clk);
        br = 1'b0; stall = 1'b0;
        total_cnt++; if (vld !== 1'b0) $display("FAIL bs_vld_drop: got %b want 0", vld); else pass_cnt++;
        total_cnt++; if (req !== 1'b1) $display("FAIL bs_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0000_0040) $display("FAIL bs_addr: got %h want 00000040", addr); else pass_cnt++;
    endtask

    task automatic test_branch_in_req();
        br = 1'b1; tgt = 32'h0000_0083;
        @(negedge clk);
        br = 1'b0;
        total_cnt++; if (req !== 1'b0) $display("FAIL br_req_drop: got %b want 0", req); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL br_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0000_0080) $display("FAIL br_addr: got %h want 00000080", addr); else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        total_cnt++; if (b_req !== 1'b1) $display("FAIL pw_req: got %b want 1", b_req); else pass_cnt++;
        total_cnt++; if (b_addr !== 32'hFFFF_FFFC) $display("FAIL pw_addr: got %h want fffffffc", b_addr); else pass_cnt++;
        b_gnt = 1'b1;
        @(negedge clk);
        b_gnt = 1'b0;
        b_rvalid = 1'b1; b_rdata = 32'h0000_0033;
        @(negedge clk);
        b_rvalid = 1'b0;
        total_cnt++; if (b_vld !== 1'b1) $display("FAIL pw_vld: got %b want 1", b_vld); else pass_cnt++;
        total_cnt++; if (b_pc !== 32'hFFFF_FFFC) $display("FAIL pw_pc: got %h want fffffffc", b_pc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (b_req !== 1'b1) $display("FAIL pw_next_req: got %b want 1", b_req); else pass_cnt++;
        total_cnt++; if (b_addr !== 32'h0000_0000) $display("FAIL pw_next_addr: got %h want 00000000", b_addr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        total_cnt++; if (addr !== 32'h0000_0080) $display("FAIL rm_pre_addr: got %h want 00000080", addr); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (req !== 1'b0) $display("FAIL rm_req: got %b want 0", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0) $display("FAIL rm_addr: got %h want 00000000", addr); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0000_0013) $display("FAIL rm_instr: got %h want 00000013", instr); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL rm_pc: got %h want 00000000", pc); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0;
        rst_n  = 1'b1;
        total_cnt++; if (vld !== 1'b0) $display("FAIL rm_stale_vld: got %b want 0", vld); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0000_0013) $display("FAIL rm_stale_instr: got %h want 00000013", instr); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL rm_req_after: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (addr !== 32'h0) $display("FAIL rm_addr_after: got %h want 00000000", addr); else pass_cnt++;
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h0050_0093;
        @(negedge clk);
        rvalid = 1'b0;
        total_cnt++; if (vld !== 1'b1) $display("FAIL rm_fetch_vld: got %b want 1", vld); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0050_0093) $display("FAIL rm_fetch_instr: got %h want 00500093", instr); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL rm_fetch_pc: got %h want 00000000", pc); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; br = 1'b0; tgt = '0; stall = 1'b0;
        b_rst_n = 1'b0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0; b_br = 1'b0; b_tgt = '0; b_stall = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_gnt_withheld();
        test_stall();
        test_branch_in_wait();
        test_branch_over_stall();
        test_branch_in_req();
        test_pc_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
